ising_run_sampler: RTL and testbench

- Run controller and phase readout stage directly downstream of the coupled-cell oscillator array.
- Owns the array's ising_rstn. Holds the oscillators in reset, releases them for a programmed anneal time, then samples every oscillator phase against a reference oscillator over a programmed window.
- Resolves each oscillator to a spin bit for the register-read path.

---
 rtl/ising_run_sampler.sv | 165 ++++++++++++++++
 tb/tb_ising_run_sampler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ising_run_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ising_run_sampler: oscillator-array run controller and phase-to-spin     |
// | readout. Optional ISING_SAMPLER_CNT_READ_EN adds final-count readback.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ising_run_sampler #(
    parameter int NUM_SPINS  = 8,
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 16,
    localparam int IDX_W     = (NUM_SPINS > 1) ? $clog2(NUM_SPINS) : 1
) (
    input  logic                 clk,
    input  logic                 axi_rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          run_len,
    input  logic [CNT_W-1:0]     sample_len,
    input  logic [NUM_SPINS-1:0] phase_in,
`ifdef ISING_SAMPLER_CNT_READ_EN
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [CNT_W-1:0]     rd_count,
`endif
    output logic                 ising_rstn,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_SPINS-1:0] spins
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_RUN    = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [NUM_SPINS-1:0]  r_ph_meta;
    logic [NUM_SPINS-1:0]  r_ph_s;
    logic [NUM_SPINS-1:0]  w_mis;
    logic [NUM_SPINS-1:0]  w_spin;
    logic [31:0]           r_run_len;
    logic [31:0]           r_timer;
    logic [CNT_W-1:0]      r_win_len;
    logic [CNT_W-1:0]      r_cnt [NUM_SPINS];
    logic                  w_accept;
    logic                  w_enter_sample;

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            r_ph_meta <= '0;
            r_ph_s    <= '0;
        end else begin
            r_ph_meta <= phase_in;
            r_ph_s    <= r_ph_meta;
        end
    end

    assign w_mis          = r_ph_s ^ {NUM_SPINS{r_ph_s[0]}};
    assign busy           = (r_state == S_RESET) || (r_state == S_RUN) || (r_state == S_SAMPLE);
    assign w_accept       = start && !abort && (r_state == S_IDLE);
    assign w_enter_sample = (r_state != S_SAMPLE) && (w_next == S_SAMPLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_RESET;
            S_RESET:  if (r_timer == 32'(RST_CYCLES - 1))
                          w_next = (r_run_len == 32'd0) ? S_SAMPLE : S_RUN;
            S_RUN:    if (r_timer == r_run_len - 32'd1) w_next = S_SAMPLE;
            S_SAMPLE: if (r_timer == 32'(r_win_len) - 32'd1) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_run_len <= '0;
            r_win_len <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_timer <= '0;
            else if (busy)
                r_timer <= r_timer + 32'd1;
            if (w_accept) begin
                r_run_len <= run_len;
                r_win_len <= (sample_len == '0) ? CNT_W'(1) : sample_len;
            end
        end
    end

    // Array reset comes straight from a flop so the coupled cells never see a decode glitch.
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            ising_rstn <= 1'b0;
            done       <= 1'b0;
            spins      <= '0;
        end else if (abort) begin
            ising_rstn <= 1'b0;
            done       <= 1'b0;
        end else if (w_accept) begin
            ising_rstn <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (r_state == S_RESET && w_next != S_RESET)
                ising_rstn <= 1'b1;
            if (r_state == S_DONE) begin
                done  <= 1'b1;
                spins <= w_spin;
            end
        end
    end

    assign w_spin[0] = 1'b0;

    generate
        for (genvar i = 0; i < NUM_SPINS; i++) begin : g_spin
            always_ff @(posedge clk or negedge axi_rstn) begin
                if (!axi_rstn)
                    r_cnt[i] <= '0;
                else if (w_enter_sample)
                    r_cnt[i] <= '0;
                else if (r_state == S_SAMPLE && w_mis[i] && r_cnt[i] != '1)
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
            if (i > 0) begin : g_decide
                // Majority vote at CNT_W+1 bits; an exact tie resolves to 0.
                assign w_spin[i] = {r_cnt[i], 1'b0} > {1'b0, r_win_len};
            end
        end
    endgenerate

`ifdef ISING_SAMPLER_CNT_READ_EN
    logic [CNT_W-1:0] r_final [NUM_SPINS];

    generate
        for (genvar j = 0; j < NUM_SPINS; j++) begin : g_final
            always_ff @(posedge clk or negedge axi_rstn) begin
                if (!axi_rstn)
                    r_final[j] <= '0;
                else if (r_state == S_DONE && !abort)
                    r_final[j] <= r_cnt[j];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn)
            rd_count <= '0;
        else if (32'(rd_idx) < NUM_SPINS)
            rd_count <= r_final[rd_idx];
        else
            rd_count <= '0;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ising_run_sampler.sv
`default_nettype none
// Randomized bench for ising_run_sampler with a window-counting reference model.
module tb_ising_run_sampler;
    localparam int NS  = 8;
    localparam int RST = 4;
    localparam int CW  = 16;

    logic          clk        = 1'b0;
    logic          axi_rstn   = 1'b0;
    logic          start      = 1'b0;
    logic          abort      = 1'b0;
    logic [31:0]   run_len    = '0;
    logic [CW-1:0] sample_len = '0;
    logic [NS-1:0] phase_in   = '0;
    logic          ising_rstn;
    logic          busy;
    logic          done;
    logic [NS-1:0] spins;
`ifdef ISING_SAMPLER_CNT_READ_EN
    logic [2:0]    rd_idx = '0;
    logic [CW-1:0] rd_count;
`endif

    ising_run_sampler #(.NUM_SPINS(NS), .RST_CYCLES(RST), .CNT_W(CW)) dut (
        .clk        (clk),
        .axi_rstn   (axi_rstn),
        .start      (start),
        .abort      (abort),
        .run_len    (run_len),
        .sample_len (sample_len),
        .phase_in   (phase_in),
`ifdef ISING_SAMPLER_CNT_READ_EN
        .rd_idx     (rd_idx),
        .rd_count   (rd_count),
`endif
        .ising_rstn (ising_rstn),
        .busy       (busy),
        .done       (done),
        .spins      (spins)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            edge_n = 0;
    int            ph_mode = 0;
    int            ph_s0 = 0;
    logic [NS-1:0] hist [int];
    logic [NS-1:0] last_spins = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Phase value presented to the DUT ahead of edge e.
    function automatic logic [NS-1:0] gen_phase(input int e);
        logic r;
        case (ph_mode)
            1: begin
                r = ((e / 3) % 2) == 1;
                return {{4{~r}}, {4{r}}};
            end
            2: return ((e == ph_s0 - 1) || (e == ph_s0)) ? 8'h02 : 8'h00;
            3: return 8'h20;
            default: return NS'($urandom);
        endcase
    endfunction

    task automatic step();
        logic [NS-1:0] p;
        p = gen_phase(edge_n + 1);
        hist[edge_n + 1] = p;
        phase_in = p;
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    // Samples counted at edges s0+1..s0+L see the phase driven two edges earlier.
    function automatic int model_count(input int s0, input int len, input int idx);
        int c = 0;
        for (int e = s0 + 1; e <= s0 + len; e++) begin
            logic [NS-1:0] v;
            v = hist[e - 2];
            if (v[idx] != v[0]) c++;
        end
        return c;
    endfunction

    function automatic logic [NS-1:0] model_spins(input int s0, input int len);
        logic [NS-1:0] s = '0;
        for (int i = 1; i < NS; i++)
            s[i] = (2 * model_count(s0, len, i)) > len;
        return s;
    endfunction

    task automatic do_run(input int rl, input int sl, input int mode, input int intr);
        int L;
        int t;
        int s0;
        int low;
        int done_edge;
        logic [NS-1:0] exp;
        L = (sl == 0) ? 1 : sl;
        t = edge_n + 1;
        s0 = t + RST + rl;
        low = 0;
        done_edge = -1;
        ph_mode = mode;
        ph_s0 = s0;
        start = 1'b1;
        run_len = rl;
        sample_len = CW'(sl);
        step();
        start = 1'b0;
        check_val("start_done_clr", done, 0);
        check_val("start_busy", busy, 1);
        if (!ising_rstn) low++;
        for (int k = 1; k < RST + rl + L + 40; k++) begin
            if (k == intr) begin
                start = 1'b1;
                run_len = rl + 37;
                sample_len = CW'(sl + 9);
            end
            step();
            start = 1'b0;
            if (!ising_rstn) low++;
            if (done) begin
                done_edge = edge_n;
                break;
            end
        end
        exp = model_spins(s0, L);
        check_val("done_latency", done_edge, s0 + L + 1);
        check_val("spins", spins, exp);
        check_val("rstn_low_cycles", low, RST);
        last_spins = exp;
        step();
        check_val("idle_after_done_busy", busy, 0);
        check_val("done_sticky", done, 1);
    endtask

    initial begin
        logic changed;
        ph_mode = 0;
        repeat (3) step();
        axi_rstn = 1'b1;
        step();
        check_val("rst_ising_rstn", ising_rstn, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_spins", spins, 0);
        changed = 1'b0;
        repeat (100) begin
            step();
            if (ising_rstn || busy || done || spins != '0) changed = 1'b1;
        end
        check_val("idle_hold", changed, 0);

        do_run(10, 20, 1, -1);
        check_val("coherent_f0", spins, 8'hF0);

        do_run(0, 6, 0, -1);
        do_run(3, 0, 0, -1);
        do_run(2, 4, 2, -1);
        check_val("tie_spin1", spins[1], 0);
        repeat (6) do_run($urandom_range(0, 12), $urandom_range(0, 25), 0, -1);
        do_run(5, 10, 0, RST + 5 + 2);

        // Abort during RUN.
        ph_mode = 0;
        start = 1'b1;
        run_len = 20;
        sample_len = 5;
        step();
        start = 1'b0;
        repeat (RST + 3) step();
        check_val("pre_abort_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("abort_rstn", ising_rstn, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_spins", spins, last_spins);

        abort = 1'b1;
        start = 1'b1;
        run_len = 3;
        step();
        abort = 1'b0;
        start = 1'b0;
        check_val("abort_wins_busy", busy, 0);
        repeat (3) step();
        check_val("abort_wins_rstn", ising_rstn, 0);

        do_run(1, 3, 0, -1);

        // Asynchronous reset in the middle of SAMPLE.
        start = 1'b1;
        run_len = 2;
        sample_len = 30;
        step();
        start = 1'b0;
        repeat (RST + 2 + 3) step();
        check_val("pre_arst_rstn", ising_rstn, 1);
        #2 axi_rstn = 1'b0;
        #1;
        check_val("arst_rstn", ising_rstn, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_spins", spins, 0);
        step();
        axi_rstn = 1'b1;
        step();

`ifdef ISING_SAMPLER_CNT_READ_EN
        do_run(0, 100, 3, -1);
        rd_idx = 3'd5;
        step();
        check_val("rd_count_5", rd_count, 100);
        rd_idx = 3'd0;
        step();
        check_val("rd_count_0", rd_count, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
